// File: rtl/stream_video_filter_pkg.sv
// rtl/stream_video_filter_pkg.sv - shared constants and elaboration helpers for the stream video filters
package stream_video_filter_pkg;

    localparam int DEFAULT_KERNEL_DIM = 5;
    localparam int DEFAULT_CH_W       = 8;
    localparam int DEFAULT_CHANNELS   = 3;
    localparam int DEFAULT_MAX_WIDTH  = 1920;
    localparam int RECIP_SHIFT        = 16;

    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

    // Fixed-point 1/(k*k) with RECIP_SHIFT fractional bits, rounded to nearest.
    function automatic int recip(input int k);
        return ((1 << RECIP_SHIFT) + (k * k) / 2) / (k * k);
    endfunction

    function automatic int pix_width(input int ch_w, input int channels);
        return ch_w * channels;
    endfunction

endpackage

// File: rtl/video_line_buffer.sv
// rtl/video_line_buffer.sv - one video line of storage, read-before-write at a shared address
module video_line_buffer
    import stream_video_filter_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_MAX_WIDTH,
    parameter int WIDTH  = 24,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The old word is visible combinationally so the next buffer in the chain can take it this cycle.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/stream_video_box_filter.sv
// rtl/stream_video_box_filter.sv - KxK mean filter on a video stream; VIDEO_FILTER_ROUND_EN selects round-to-nearest
module stream_video_box_filter
    import stream_video_filter_pkg::*;
#(
    parameter int KERNEL_DIM = DEFAULT_KERNEL_DIM,
    parameter int CH_W       = DEFAULT_CH_W,
    parameter int CHANNELS   = DEFAULT_CHANNELS,
    parameter int MAX_WIDTH  = DEFAULT_MAX_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS*CH_W-1:0]   s_axis_video_tdata,
    input  logic                       s_axis_video_tvalid,
    output logic                       s_axis_video_tready,
    input  logic                       s_axis_video_tuser,
    input  logic                       s_axis_video_tlast,
    output logic [CHANNELS*CH_W-1:0]   m_axis_video_tdata,
    output logic                       m_axis_video_tvalid,
    input  logic                       m_axis_video_tready,
    output logic                       m_axis_video_tuser,
    output logic                       m_axis_video_tlast
);

    localparam int PIX_W  = pix_width(CH_W, CHANNELS);
    localparam int LINES  = KERNEL_DIM - 1;
    localparam int COL_W  = clog2(MAX_WIDTH + 1);
    localparam int ADDR_W = (MAX_WIDTH > 1) ? clog2(MAX_WIDTH) : 1;
    localparam int ROW_W  = clog2(KERNEL_DIM);
    localparam int CSUM_W = CH_W + clog2(KERNEL_DIM);
    localparam int SUM_W  = CH_W + clog2(KERNEL_DIM * KERNEL_DIM);
    localparam int RECIP  = recip(KERNEL_DIM);
    localparam int PROD_W = SUM_W + RECIP_SHIFT + 1;
    localparam int CH_MAX = (1 << CH_W) - 1;

    logic adv;
    logic in_fire;

    assign adv                 = !m_axis_video_tvalid || m_axis_video_tready;
    assign s_axis_video_tready = adv && !reset;
    assign in_fire             = s_axis_video_tvalid && s_axis_video_tready;

    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  cur_row;
    logic              frame_first;
    logic              in_range;
    logic              win_ok;
    logic              first_hit;
    logic [ADDR_W-1:0] lb_addr;
    logic              lb_wr_en;

    assign cur_col   = s_axis_video_tuser ? '0 : col;
    assign cur_row   = s_axis_video_tuser ? '0 : row;
    assign in_range  = cur_col < COL_W'(MAX_WIDTH);
    assign win_ok    = in_range && (cur_row == ROW_W'(KERNEL_DIM - 1)) && (cur_col >= COL_W'(KERNEL_DIM - 1));
    // Row saturates at K-1, so a separate flag marks the first full window of the frame.
    assign first_hit = win_ok && frame_first;
    assign lb_addr   = in_range ? cur_col[ADDR_W-1:0] : '0;
    assign lb_wr_en  = in_fire && in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            col         <= '0;
            row         <= '0;
            frame_first <= 1'b0;
        end else if (in_fire) begin
            if (s_axis_video_tlast) begin
                col <= '0;
                row <= (cur_row == ROW_W'(KERNEL_DIM - 1)) ? cur_row : cur_row + ROW_W'(1);
            end else begin
                col <= (cur_col == COL_W'(MAX_WIDTH)) ? cur_col : cur_col + COL_W'(1);
                row <= cur_row;
            end
            if (s_axis_video_tuser) begin
                frame_first <= 1'b1;
            end else if (win_ok) begin
                frame_first <= 1'b0;
            end
        end
    end

    logic [PIX_W-1:0] lb_wr [LINES];
    logic [PIX_W-1:0] lb_rd [LINES];

    for (genvar i = 0; i < LINES; i++) begin : g_line
        if (i == 0) begin : g_head
            assign lb_wr[i] = s_axis_video_tdata;
        end else begin : g_tail
            assign lb_wr[i] = lb_rd[i-1];
        end
        video_line_buffer #(
            .DEPTH  (MAX_WIDTH),
            .WIDTH  (PIX_W),
            .ADDR_W (ADDR_W)
        ) u_line (
            .clk     (clk),
            .wr_en   (lb_wr_en),
            .addr    (lb_addr),
            .wr_data (lb_wr[i]),
            .rd_data (lb_rd[i])
        );
    end

    logic             s1_valid;
    logic             s1_ok;
    logic             s1_first;
    logic             s1_last;
    logic [PIX_W-1:0] s1_pix;
    logic [PIX_W-1:0] s1_lines [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ok    <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_fire;
            s1_ok    <= in_fire && win_ok;
            s1_first <= in_fire && first_hit;
            s1_last  <= in_fire && s_axis_video_tlast;
            s1_pix   <= s_axis_video_tdata;
            s1_lines <= lb_rd;
        end
    end

    // The window is held as per-column vertical sums; the mean only needs their total.
    logic [CSUM_W-1:0] new_csum [CHANNELS];

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            new_csum[ch] = CSUM_W'(s1_pix[ch*CH_W +: CH_W]);
            for (int i = 0; i < LINES; i++) begin
                new_csum[ch] = new_csum[ch] + CSUM_W'(s1_lines[i][ch*CH_W +: CH_W]);
            end
        end
    end

    logic              s2_ok;
    logic              s2_first;
    logic              s2_last;
    logic [CSUM_W-1:0] csum [KERNEL_DIM][CHANNELS];

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_ok    <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            for (int k = 0; k < KERNEL_DIM; k++) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    csum[k][ch] <= '0;
                end
            end
        end else if (adv) begin
            s2_ok    <= s1_valid && s1_ok;
            s2_first <= s1_valid && s1_first;
            s2_last  <= s1_valid && s1_ok && s1_last;
            if (s1_valid) begin
                csum[0] <= new_csum;
                for (int k = 1; k < KERNEL_DIM; k++) begin
                    csum[k] <= csum[k-1];
                end
            end
        end
    end

    logic [SUM_W-1:0]  total [CHANNELS];
    logic [PROD_W-1:0] prod  [CHANNELS];
    logic [PROD_W-1:0] quo   [CHANNELS];
    logic [PIX_W-1:0]  filt;

    always_comb begin
        filt = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            total[ch] = '0;
            for (int k = 0; k < KERNEL_DIM; k++) begin
                total[ch] = total[ch] + SUM_W'(csum[k][ch]);
            end
            prod[ch] = PROD_W'(total[ch]) * PROD_W'(RECIP);
`ifdef VIDEO_FILTER_ROUND_EN
            prod[ch] = prod[ch] + PROD_W'(1 << (RECIP_SHIFT - 1));
`else
            prod[ch] = prod[ch];
`endif
            quo[ch] = prod[ch] >> RECIP_SHIFT;
            filt[ch*CH_W +: CH_W] = (quo[ch] > PROD_W'(CH_MAX)) ? CH_W'(CH_MAX) : quo[ch][CH_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_video_tvalid <= 1'b0;
            m_axis_video_tuser  <= 1'b0;
            m_axis_video_tlast  <= 1'b0;
            m_axis_video_tdata  <= '0;
        end else if (adv) begin
            m_axis_video_tvalid <= s2_ok;
            m_axis_video_tuser  <= s2_first;
            m_axis_video_tlast  <= s2_last;
            if (s2_ok) begin
                m_axis_video_tdata <= filt;
            end
        end
    end

endmodule

// File: tb/tb_stream_video_box_filter.sv
// tb/tb_stream_video_box_filter.sv - directed self-checking bench for stream_video_box_filter at K=3
module tb_stream_video_box_filter;

    localparam int K         = 3;
    localparam int CH_W      = 8;
    localparam int CHANNELS  = 3;
    localparam int MAX_WIDTH = 16;
    localparam int PIX_W     = CH_W * CHANNELS;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic [PIX_W-1:0] s_tdata  = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic             s_tuser  = 1'b0;
    logic             s_tlast  = 1'b0;
    logic [PIX_W-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready = 1'b1;
    logic             m_tuser;
    logic             m_tlast;

    int   checks     = 0;
    int   passed     = 0;
    int   ready_mode = 0;
    logic abort      = 1'b0;
    int   stall_errs = 0;

    logic [PIX_W-1:0] got_data [$];
    logic             got_user [$];
    logic             got_last [$];

    stream_video_box_filter #(
        .KERNEL_DIM (K),
        .CH_W       (CH_W),
        .CHANNELS   (CHANNELS),
        .MAX_WIDTH  (MAX_WIDTH)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tuser  (s_tuser),
        .s_axis_video_tlast  (s_tlast),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tready (m_tready),
        .m_axis_video_tuser  (m_tuser),
        .m_axis_video_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [PIX_W-1:0] pix(input int mode, input int c, input int r);
        logic [CH_W-1:0] v;
        case (mode)
            0:       v = 8'd100;
            1:       v = CH_W'(c * 10);
            2:       v = (c == 1 && r == 1) ? 8'd5 : 8'd0;
            default: v = 8'd200;
        endcase
        return {CHANNELS{v}};
    endfunction

    function automatic logic [PIX_W-1:0] rep(input int v);
        logic [CH_W-1:0] b;
        b = CH_W'(v);
        return {CHANNELS{b}};
    endfunction

    task automatic send_frame(input int w, input int h, input int mode, input int stop_row, input int stop_col);
        logic rdy;
        int   budget;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (abort || (r == stop_row && c == stop_col)) begin
                    s_tvalid = 1'b0;
                    return;
                end
                s_tdata  = pix(mode, c, r);
                s_tuser  = (r == 0 && c == 0);
                s_tlast  = (c == w - 1);
                s_tvalid = 1'b1;
                rdy      = 1'b0;
                budget   = 0;
                while (!rdy && !abort && budget < 200) begin
                    @(negedge clk);
                    rdy = s_tready;
                    @(posedge clk);
                    #1;
                    budget++;
                end
                if (!rdy && !abort) begin
                    checks++;
                    $display("FAIL send_timeout: pixel row %0d col %0d not accepted, got ready=0 want 1", r, c);
                    s_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic collect(input int n);
        logic             held;
        logic [PIX_W-1:0] held_data;
        int               cyc;
        int               tail;
        got_data.delete();
        got_user.delete();
        got_last.delete();
        stall_errs = 0;
        held       = 1'b0;
        held_data  = '0;
        cyc        = 0;
        tail       = 0;
        while (tail < 20 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (held && (!m_tvalid || m_tdata !== held_data)) stall_errs++;
            if (m_tvalid && m_tready) begin
                got_data.push_back(m_tdata);
                got_user.push_back(m_tuser);
                got_last.push_back(m_tlast);
            end
            held      = m_tvalid && !m_tready;
            held_data = m_tdata;
            if (got_data.size() >= n) tail++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_tvalid); else passed++;
        checks++; if (m_tuser !== 1'b0) $display("FAIL rst_tuser: got %b want 0", m_tuser); else passed++;
        checks++; if (m_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", m_tlast); else passed++;
        checks++; if (m_tdata !== '0) $display("FAIL rst_tdata: got %h want 0", m_tdata); else passed++;
        checks++; if (s_tready !== 1'b0) $display("FAIL rst_tready_low: got %b want 0", s_tready); else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (s_tready !== 1'b1) $display("FAIL rst_tready_high: got %b want 1", s_tready); else passed++;
    endtask

    task automatic test_constant;
        @(posedge clk); #1;
        fork
            send_frame(8, 4, 0, -1, -1);
            collect(12);
        join
        checks++; if (got_data.size() != 12) $display("FAIL const_count: got %0d want 12", got_data.size()); else passed++;
        for (int i = 0; i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== rep(100)) $display("FAIL const_data[%0d]: got %h want %h", i, got_data[i], rep(100)); else passed++;
            checks++; if (got_user[i] !== (i == 0)) $display("FAIL const_user[%0d]: got %b want %b", i, got_user[i], (i == 0)); else passed++;
            checks++; if (got_last[i] !== (i == 5 || i == 11)) $display("FAIL const_last[%0d]: got %b want %b", i, got_last[i], (i == 5 || i == 11)); else passed++;
        end
    endtask

    task automatic test_ramp;
        @(posedge clk); #1;
        fork
            send_frame(10, 3, 1, -1, -1);
            collect(8);
        join
        checks++; if (got_data.size() != 8) $display("FAIL ramp_count: got %0d want 8", got_data.size()); else passed++;
        for (int i = 0; i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== rep((i + 1) * 10)) $display("FAIL ramp_data[%0d]: got %h want %h", i, got_data[i], rep((i + 1) * 10)); else passed++;
            checks++; if (got_last[i] !== (i == 7)) $display("FAIL ramp_last[%0d]: got %b want %b", i, got_last[i], (i == 7)); else passed++;
        end
    endtask

    task automatic test_single;
        int expv;
`ifdef VIDEO_FILTER_ROUND_EN
        expv = 1;
`else
        expv = 0;
`endif
        @(posedge clk); #1;
        fork
            send_frame(3, 3, 2, -1, -1);
            collect(1);
        join
        checks++; if (got_data.size() != 1) $display("FAIL single_count: got %0d want 1", got_data.size()); else passed++;
        if (got_data.size() >= 1) begin
            checks++; if (got_data[0] !== rep(expv)) $display("FAIL single_data: got %h want %h", got_data[0], rep(expv)); else passed++;
            checks++; if (got_user[0] !== 1'b1 || got_last[0] !== 1'b1) $display("FAIL single_flags: got user=%b last=%b want 1 1", got_user[0], got_last[0]); else passed++;
        end
    endtask

    task automatic test_backpressure;
        ready_mode = 1;
        @(posedge clk); #1;
        fork
            send_frame(8, 4, 3, -1, -1);
            collect(12);
        join
        ready_mode = 0;
        checks++; if (got_data.size() != 12) $display("FAIL bp_count: got %0d want 12", got_data.size()); else passed++;
        checks++; if (stall_errs != 0) $display("FAIL bp_stable: got %0d unstable stalled beats want 0", stall_errs); else passed++;
        for (int i = 0; i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== rep(200)) $display("FAIL bp_data[%0d]: got %h want %h", i, got_data[i], rep(200)); else passed++;
        end
    endtask

    task automatic test_tuser_midline;
        @(posedge clk); #1;
        fork
            begin
                send_frame(8, 4, 0, 2, 3);
                send_frame(8, 4, 3, -1, -1);
            end
            collect(13);
        join
        checks++; if (got_data.size() != 13) $display("FAIL mid_count: got %0d want 13", got_data.size()); else passed++;
        if (got_data.size() >= 2) begin
            checks++; if (got_data[0] !== rep(100) || got_user[0] !== 1'b1) $display("FAIL mid_old_beat: got %h user %b want %h user 1", got_data[0], got_user[0], rep(100)); else passed++;
            checks++; if (got_user[1] !== 1'b1) $display("FAIL mid_new_user: got %b want 1", got_user[1]); else passed++;
        end
        for (int i = 1; i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== rep(200)) $display("FAIL mid_data[%0d]: got %h want %h", i, got_data[i], rep(200)); else passed++;
            checks++; if (got_last[i] !== (i == 6 || i == 12)) $display("FAIL mid_last[%0d]: got %b want %b", i, got_last[i], (i == 6 || i == 12)); else passed++;
            if (i >= 2) begin
                checks++; if (got_user[i] !== 1'b0) $display("FAIL mid_user[%0d]: got %b want 0", i, got_user[i]); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        abort = 1'b0;
        fork
            send_frame(8, 4, 0, -1, -1);
            begin
                int cyc;
                cyc = 0;
                while (!m_tvalid && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                end
                checks++; if (m_tvalid !== 1'b1) $display("FAIL rmid_output_seen: got %b want 1", m_tvalid); else passed++;
                @(posedge clk); #1;
                reset = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                checks++; if (s_tready !== 1'b0) $display("FAIL rmid_tready_low: got %b want 0", s_tready); else passed++;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                checks++; if (m_tvalid !== 1'b0) $display("FAIL rmid_tvalid: got %b want 0", m_tvalid); else passed++;
                checks++; if (s_tready !== 1'b1) $display("FAIL rmid_tready_high: got %b want 1", s_tready); else passed++;
            end
        join
        abort = 1'b0;
        @(posedge clk); #1;
        fork
            send_frame(8, 4, 3, -1, -1);
            collect(12);
        join
        checks++; if (got_data.size() != 12) $display("FAIL rmid_count: got %0d want 12", got_data.size()); else passed++;
        for (int i = 0; i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== rep(200)) $display("FAIL rmid_data[%0d]: got %h want %h", i, got_data[i], rep(200)); else passed++;
            checks++; if (got_user[i] !== (i == 0)) $display("FAIL rmid_user[%0d]: got %b want %b", i, got_user[i], (i == 0)); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_single();
        test_backpressure();
        test_tuser_midline();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
